seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 103 ++++++++++
 tb/tb_seg_scan_driver.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// seg_scan_driver: time-multiplexed 8-digit hex 7-segment scanner with
// frame-synchronous display update, leading-zero blanking and per-digit dp.
// Revision: 1.0
// ============================================================================
module seg_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        valid,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_mask,
  input  logic        blank_lz,
  output logic [6:0]  SEG,
  output logic [7:0]  AN,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   disp_q, disp_d;
  logic [6:0]    seg_q, seg_d;
  logic [7:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic          fd_q, fd_d;

  logic          tick, wrap, dark;
  logic [3:0]    nib;
  logic [7:0]    upper_zero;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    tick     = (cnt_q == CNT_LAST);
    wrap     = tick && (idx_q == 3'd7);
    cnt_d    = tick ? '0 : cnt_q + CW'(1);
    idx_d    = tick ? idx_q + 3'd1 : idx_q;
    shadow_d = valid ? value : shadow_q;
    // Display only moves at the frame boundary so a scan never mixes two values.
    disp_d   = wrap ? (valid ? value : shadow_q) : disp_q;

    // upper_zero[k] is set when nibbles k..7 of the display are all zero.
    upper_zero    = '0;
    upper_zero[7] = (disp_q[31:28] == 4'h0);
    for (int k = 6; k >= 0; k--) begin
      upper_zero[k] = upper_zero[k+1] && (disp_q[4*k +: 4] == 4'h0);
    end

    nib  = disp_q[{idx_q, 2'b00} +: 4];
    dark = !digit_en[idx_q] || (blank_lz && (idx_q != 3'd0) && upper_zero[idx_q]);

    an_d  = dark ? 8'hFF : ~(8'h01 << idx_q);
    seg_d = dark ? 7'h7F : decode(nib);
    dp_d  = dark ? 1'b1  : ~dp_mask[idx_q];
    fd_d  = wrap;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shadow_q <= 32'h0;
      disp_q   <= 32'h0;
      seg_q    <= 7'h7F;
      an_q     <= 8'hFF;
      dp_q     <= 1'b1;
      fd_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      dp_q     <= dp_d;
      fd_q     <= fd_d;
    end
  end

  assign SEG        = seg_q;
  assign AN         = an_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// tb_seg_scan_driver: checks seg_scan_driver (REFRESH_DIV=4) against a
// slot-arithmetic model every cycle, plus literal anchor points.
// Revision: 1.0
// ============================================================================
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value;
  logic        valid;
  logic [7:0]  digit_en;
  logic [7:0]  dp_mask;
  logic        blank_lz;
  logic [6:0]  SEG;
  logic [7:0]  AN;
  logic        dp;
  logic        frame_done;

  seg_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .value(value), .valid(valid),
    .digit_en(digit_en), .dp_mask(dp_mask), .blank_lz(blank_lz),
    .SEG(SEG), .AN(AN), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  // m_t = number of clocked edges since reset release
  int          m_t = 0;
  logic [31:0] m_disp = 32'h0;
  logic [31:0] m_shadow = 32'h0;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Per-cycle reference comparison.
  always begin : p_compare
    logic [6:0] e_seg;
    logic [7:0] e_an;
    logic       e_dp, e_fd, dk;
    int         k;
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_t = 0; m_disp = 32'h0; m_shadow = 32'h0;
      e_seg = 7'h7F; e_an = 8'hFF; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      k     = (m_t / 4) % 8;
      dk    = !digit_en[k] || (blank_lz && k > 0 && (m_disp >> (4*k)) == 32'h0);
      e_an  = dk ? 8'hFF : ~(8'h01 << k);
      e_seg = dk ? 7'h7F : seg_of(4'((m_disp >> (4*k)) & 32'hF));
      e_dp  = dk ? 1'b1 : !dp_mask[k];
      e_fd  = (m_t % 32 == 31);
      if (m_t % 32 == 31) m_disp = valid ? value : m_shadow;
      if (valid) m_shadow = value;
      m_t++;
    end
    #1;
    n_vec++;
    if (SEG !== e_seg || AN !== e_an || dp !== e_dp || frame_done !== e_fd) begin
      n_err++;
      $display("FAIL cycle t=%0d: got SEG=%h AN=%h dp=%b fd=%b, expected SEG=%h AN=%h dp=%b fd=%b",
               m_t, SEG, AN, dp, frame_done, e_seg, e_an, e_dp, e_fd);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Advance to 2 time units after edge number target.
  task automatic goto(input int target);
    int guard = 0;
    while (m_t != target + 1 && guard < 5000) begin
      @(posedge clk); #2; guard++;
    end
    if (guard >= 5000) begin
      n_err++;
      $display("FAIL goto timeout: at t=%0d, wanted %0d", m_t, target);
    end
  endtask

  initial begin
    int cur, base;
    rst = 1'b0; valid = 1'b1; value = 32'hDEADBEEF;
    digit_en = 8'hFF; dp_mask = 8'h00; blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_AN", 32'(AN), 32'hFF);
    chk("reset_SEG", 32'(SEG), 32'h7F);
    rst = 1'b1; valid = 1'b0;

    goto(0);   chk("d0_AN", 32'(AN), 32'hFE); chk("d0_SEG", 32'(SEG), 32'h40);
    goto(4);   chk("d1_AN", 32'(AN), 32'hFD);
    goto(28);  chk("d7_AN", 32'(AN), 32'h7F);
    goto(31);  chk("frame_done", 32'(frame_done), 32'h1);

    goto(38);  valid = 1'b1; value = 32'h89ABCDEF;
    goto(39);  valid = 1'b0;
    goto(40);  chk("no_tear_SEG", 32'(SEG), 32'h40);
    goto(64);  chk("load_d0_SEG", 32'(SEG), 32'h0E);
    goto(92);  chk("load_d7_SEG", 32'(SEG), 32'h00);

    goto(94);  valid = 1'b1; value = 32'h00000007;
    goto(95);  valid = 1'b0;
    goto(96);  chk("bypass_SEG", 32'(SEG), 32'h78);

    goto(100); blank_lz = 1'b1; valid = 1'b1; value = 32'h00000105;
    goto(101); valid = 1'b0;
    goto(128); chk("lz_d0_SEG", 32'(SEG), 32'h12);
    goto(132); chk("lz_d1_SEG", 32'(SEG), 32'h40);
    goto(136); chk("lz_d2_SEG", 32'(SEG), 32'h79);
    goto(140); chk("lz_d3_AN", 32'(AN), 32'hFF); chk("lz_d3_SEG", 32'(SEG), 32'h7F);

    goto(144); valid = 1'b1; value = 32'h0;
    goto(145); valid = 1'b0;
    goto(160); chk("zero_d0_AN", 32'(AN), 32'hFE); chk("zero_d0_SEG", 32'(SEG), 32'h40);
    goto(164); chk("zero_d1_AN", 32'(AN), 32'hFF);

    goto(180); blank_lz = 1'b0; digit_en = 8'hFE; dp_mask = 8'h02;
    goto(192); chk("en_d0_AN", 32'(AN), 32'hFF);
    goto(196); chk("dp_d1_AN", 32'(AN), 32'hFD); chk("dp_d1", 32'(dp), 32'h0);
    goto(200); chk("dp_d2", 32'(dp), 32'h1);

    for (int i = 0; i < 700; i++) begin
      @(posedge clk); #2;
      valid    = ($urandom_range(0, 7) == 0);
      value    = $urandom >> (4 * $urandom_range(0, 8));
      digit_en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      dp_mask  = 8'($urandom);
      blank_lz = 1'($urandom);
    end

    cur = m_t - 1;
    valid = 1'b1; value = 32'h11111111;
    digit_en = 8'hFF; dp_mask = 8'h00; blank_lz = 1'b0;
    goto(cur + 1); valid = 1'b0;
    base = ((cur + 1) / 32 + 1) * 32 + 21;
    goto(base);
    chk("pre_rst_AN", 32'(AN), 32'hDF);
    chk("pre_rst_SEG", 32'(SEG), 32'h79);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_AN", 32'(AN), 32'hFF);
    chk("async_rst_SEG", 32'(SEG), 32'h7F);
    chk("async_rst_fd", 32'(frame_done), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    goto(0);   chk("post_rst_AN", 32'(AN), 32'hFE); chk("post_rst_SEG", 32'(SEG), 32'h40);
    goto(31);  chk("post_rst_fd", 32'(frame_done), 32'h1);
    goto(36);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
